// File: rtl/c2_line_mem.sv
// C2-bus main-memory model: line-granular storage serviced by burst READ/WRITE
// transactions, answering with RESPONSE after a fixed access latency.
module c2_line_mem #(
    parameter int unsigned MEM_ADDR_SIZE     = 19,
    parameter int unsigned CACHE_OFFSET_SIZE = 4,
    parameter int unsigned CACHE_LINE_SIZE   = 16,
    parameter int unsigned BUS_SIZE          = 16,
    parameter int unsigned MEM_LATENCY       = 100
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [MEM_ADDR_SIZE-CACHE_OFFSET_SIZE-1:0] address,
    inout  wire  [BUS_SIZE-1:0]                        data,
    inout  wire  [1:0]                                 command
);

    localparam int unsigned LINE_W = CACHE_LINE_SIZE * 8;
    localparam int unsigned BEATS  = LINE_W / BUS_SIZE;
    localparam int unsigned AW     = MEM_ADDR_SIZE - CACHE_OFFSET_SIZE;
    localparam int unsigned LINES  = 2 ** AW;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned LAT_W  = $clog2(MEM_LATENCY + 1);

    localparam logic [1:0] CMD_RESP  = 2'd1;
    localparam logic [1:0] CMD_READ  = 2'd2;
    localparam logic [1:0] CMD_WRITE = 2'd3;

    typedef enum logic [1:0] {IDLE, WR_RX, WAIT, RESP} state_t;

    state_t              state;
    logic                is_write;
    logic [AW-1:0]       addr_q;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [LAT_W-1:0]    lat_cnt;
    logic [LINE_W-1:0]   line_buf;
    logic                drive_cmd;
    logic                drive_data;

    logic [LINE_W-1:0]   storage [LINES];

    logic [LINE_W-1:0]   wr_line_c;
    logic                mem_we_c;
    logic [AW-1:0]       wr_addr_c;

    // Line buffer with the beat currently on the bus merged in; committed atomically.
    always_comb begin
        wr_line_c = line_buf;
        wr_line_c[beat_cnt*BUS_SIZE +: BUS_SIZE] = data;
        mem_we_c  = reset &&
                    (((state == IDLE) && (command == CMD_WRITE) && (BEATS == 1)) ||
                     ((state == WR_RX) && (beat_cnt == BEAT_W'(BEATS - 1))));
        wr_addr_c = (state == IDLE) ? address : addr_q;
    end

    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            storage[wr_addr_c] <= wr_line_c;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            is_write   <= 1'b0;
            addr_q     <= '0;
            beat_cnt   <= '0;
            lat_cnt    <= '0;
            line_buf   <= '0;
            drive_cmd  <= 1'b0;
            drive_data <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (command == CMD_READ) begin
                        addr_q   <= address;
                        is_write <= 1'b0;
                        if (MEM_LATENCY == 1) begin
                            state      <= RESP;
                            drive_cmd  <= 1'b1;
                            drive_data <= 1'b1;
                            line_buf   <= storage[address];
                        end else begin
                            state   <= WAIT;
                            lat_cnt <= LAT_W'(MEM_LATENCY - 1);
                        end
                    end else if (command == CMD_WRITE) begin
                        addr_q   <= address;
                        is_write <= 1'b1;
                        line_buf <= wr_line_c;
                        if (BEATS > 1) begin
                            state    <= WR_RX;
                            beat_cnt <= BEAT_W'(1);
                        end else if (MEM_LATENCY == 1) begin
                            state     <= RESP;
                            drive_cmd <= 1'b1;
                        end else begin
                            state   <= WAIT;
                            lat_cnt <= LAT_W'(MEM_LATENCY - 1);
                        end
                    end
                end
                WR_RX: begin
                    line_buf <= wr_line_c;
                    if (beat_cnt == BEAT_W'(BEATS - 1)) begin
                        beat_cnt <= '0;
                        if (MEM_LATENCY == 1) begin
                            state     <= RESP;
                            drive_cmd <= 1'b1;
                        end else begin
                            state   <= WAIT;
                            lat_cnt <= LAT_W'(MEM_LATENCY - 1);
                        end
                    end else begin
                        beat_cnt <= beat_cnt + BEAT_W'(1);
                    end
                end
                WAIT: begin
                    // Leaving on the edge where the count reaches zero keeps the
                    // first RESPONSE exactly MEM_LATENCY cycles after the request.
                    if (lat_cnt == LAT_W'(1)) begin
                        state      <= RESP;
                        lat_cnt    <= '0;
                        beat_cnt   <= '0;
                        drive_cmd  <= 1'b1;
                        drive_data <= !is_write;
                        if (!is_write) begin
                            line_buf <= storage[addr_q];
                        end
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                RESP: begin
                    if (is_write || (beat_cnt == BEAT_W'(BEATS - 1))) begin
                        state      <= IDLE;
                        beat_cnt   <= '0;
                        drive_cmd  <= 1'b0;
                        drive_data <= 1'b0;
                    end else begin
                        beat_cnt <= beat_cnt + BEAT_W'(1);
                        line_buf <= line_buf >> BUS_SIZE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign command = drive_cmd  ? CMD_RESP : 2'bzz;
    assign data    = drive_data ? line_buf[BUS_SIZE-1:0] : {BUS_SIZE{1'bz}};

    // Simulation-only sanity checks on bus ownership and geometry.
    always_ff @(posedge clk) begin
        if (reset) begin
            assert (!drive_cmd || (command === CMD_RESP))
                else $error("c2_line_mem: command line contention in RESP");
            assert (!drive_data || (data === line_buf[BUS_SIZE-1:0]))
                else $error("c2_line_mem: data bus contention in RESP");
            assert (CACHE_LINE_SIZE == 2 ** CACHE_OFFSET_SIZE)
                else $error("c2_line_mem: CACHE_LINE_SIZE must be 2**CACHE_OFFSET_SIZE");
            assert ((LINE_W % BUS_SIZE) == 0)
                else $error("c2_line_mem: BUS_SIZE must divide the line width");
        end
    end

endmodule

// File: tb/tb_c2_line_mem.sv
// Self-checking bench for c2_line_mem: two instances (16-bit/latency 4 and
// 32-bit/latency 1) checked against a line-level model of the C2 protocol.
module tb_c2_line_mem;

    localparam int unsigned MAS = 12;
    localparam int unsigned AW  = MAS - 4;
    localparam logic [1:0] C_NOP = 2'd0, C_RESP = 2'd1, C_READ = 2'd2, C_WRITE = 2'd3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] addr_drv;
    logic [1:0]    cmd_drv;
    logic          cmd_en;
    logic [31:0]   data_drv;
    logic          data_en;
    logic          sel;

    wire  [1:0]    cmd_a, cmd_b;
    wire  [15:0]   data_a;
    wire  [31:0]   data_b;

    always #5 clk = ~clk;

    assign cmd_a  = (cmd_en && !sel)  ? cmd_drv         : 2'bzz;
    assign cmd_b  = (cmd_en && sel)   ? cmd_drv         : 2'bzz;
    assign data_a = (data_en && !sel) ? data_drv[15:0]  : 16'hzzzz;
    assign data_b = (data_en && sel)  ? data_drv        : 32'hzzzz_zzzz;

    c2_line_mem #(.MEM_ADDR_SIZE(MAS), .CACHE_OFFSET_SIZE(4), .CACHE_LINE_SIZE(16),
                  .BUS_SIZE(16), .MEM_LATENCY(4))
        u_mem16 (.clk(clk), .reset(rst_n), .address(addr_drv), .data(data_a), .command(cmd_a));

    c2_line_mem #(.MEM_ADDR_SIZE(MAS), .CACHE_OFFSET_SIZE(4), .CACHE_LINE_SIZE(16),
                  .BUS_SIZE(32), .MEM_LATENCY(1))
        u_mem32 (.clk(clk), .reset(rst_n), .address(addr_drv), .data(data_b), .command(cmd_b));

    int n_checks = 0;
    int n_errors = 0;
    int bw, beats, lat;
    logic [127:0] mdl   [2][256];
    bit           known [2][256];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp_v);
        n_checks++;
        if (got !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp_v, $time);
        end
    endtask

    function automatic logic [1:0] obs_cmd();
        return sel ? cmd_b : cmd_a;
    endfunction

    function automatic logic [31:0] obs_data();
        return sel ? data_b : {16'h0000, data_a};
    endfunction

    function automatic logic [127:0] beat_of(input logic [127:0] line, input int k);
        logic [127:0] mask;
        mask = (128'd1 << bw) - 128'd1;
        return (line >> (k * bw)) & mask;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic select(input logic s);
        sel   = s;
        bw    = s ? 32 : 16;
        beats = 128 / bw;
        lat   = s ? 1 : 4;
    endtask

    task automatic check_quiet(input string tag);
        cmd_en  = 1'b0;
        data_en = 1'b0;
        #1;
        check(tag, 128'(obs_cmd() === C_RESP), 128'(0));
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            check_quiet(tag);
            cyc();
        end
    endtask

    // junk: 0 = bus released and checked quiet, 1 = random traffic, 2 = READ of line 2
    task automatic drive_junk(input int junk);
        data_en = 1'b0;
        cmd_en  = 1'b1;
        if (junk == 1) begin
            cmd_drv  = 2'($urandom_range(0, 3));
            addr_drv = AW'($urandom);
        end else begin
            cmd_drv  = C_READ;
            addr_drv = AW'(2);
        end
    endtask

    task automatic wait_phase(input int junk, input string tag);
        for (int c = 1; c < lat; c++) begin
            if (junk == 0) check_quiet(tag);
            else drive_junk(junk);
            cyc();
        end
        cmd_en  = 1'b0;
        data_en = 1'b0;
        #1;
    endtask

    task automatic do_read(input int d, input logic [AW-1:0] a, input int junk, input int abort_beat);
        logic [127:0] exp_line;
        exp_line = mdl[d][a];
        addr_drv = a;
        cmd_drv  = C_READ;
        cmd_en   = 1'b1;
        data_en  = 1'b0;
        cyc();
        wait_phase(junk, "rd_wait_quiet");
        for (int k = 0; k < beats; k++) begin
            if (k == abort_beat) begin
                rst_n = 1'b0;
                #1;
                check("rd_reset_release", 128'(obs_cmd() === C_RESP), 128'(0));
                cyc();
                rst_n = 1'b1;
                idle(beats, "rd_after_reset_quiet");
                return;
            end
            check("rd_resp_cmd", 128'(obs_cmd()), 128'(C_RESP));
            check("rd_beat", 128'(obs_data()), beat_of(exp_line, k));
            cyc();
        end
        check_quiet("rd_end_quiet");
    endtask

    task automatic do_write(input int d, input logic [AW-1:0] a, input logic [127:0] line, input int junk);
        for (int k = 0; k < beats; k++) begin
            cmd_en   = 1'b1;
            data_en  = 1'b1;
            addr_drv = (k == 0 || junk == 0) ? a : AW'($urandom);
            cmd_drv  = (k == 0) ? C_WRITE : ((junk != 0) ? 2'($urandom_range(0, 3)) : C_NOP);
            data_drv = 32'(beat_of(line, k));
            cyc();
        end
        wait_phase(junk, "wr_wait_quiet");
        check("wr_resp_cmd", 128'(obs_cmd()), 128'(C_RESP));
        cyc();
        check_quiet("wr_end_quiet");
        mdl[d][a]   = line;
        known[d][a] = 1'b1;
    endtask

    task automatic rand_ops(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            logic [AW-1:0] a;
            int junk;
            junk = int'($urandom_range(0, 1));
            a    = AW'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                do_write(d, a, {$urandom, $urandom, $urandom, $urandom}, junk);
            end else begin
                while (!known[d][a]) a = AW'((a + 1) % 16);
                do_read(d, a, junk, -1);
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] line7;
        rst_n    = 1'b0;
        cmd_en   = 1'b0;
        data_en  = 1'b0;
        cmd_drv  = C_NOP;
        data_drv = '0;
        addr_drv = '0;
        select(1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset_quiet_16");
        select(1'b1);
        check_quiet("reset_quiet_32");
        rst_n = 1'b1;
        select(1'b0);
        cyc();

        // Known line, then a read timed against latency and beat order.
        do_write(0, AW'(5), 128'h0F0E0D0C_0B0A0908_07060504_03020100, 0);
        do_read(0, AW'(5), 0, -1);

        line7 = {16'h8888, 16'h7777, 16'h6666, 16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111};
        do_write(0, AW'(7), line7, 0);
        do_read(0, AW'(7), 0, -1);

        // Reset in the middle of a write burst leaves the line untouched.
        do_write(0, AW'(3), 128'h0, 0);
        for (int k = 0; k < 4; k++) begin
            addr_drv = AW'(3);
            cmd_drv  = (k == 0) ? C_WRITE : C_NOP;
            cmd_en   = 1'b1;
            data_drv = 32'h0000_FFFF;
            data_en  = 1'b1;
            cyc();
        end
        cmd_en  = 1'b0;
        data_en = 1'b0;
        rst_n   = 1'b0;
        #1;
        check("wr_reset_release", 128'(obs_cmd() === C_RESP), 128'(0));
        cyc();
        rst_n = 1'b1;
        idle(lat + 2, "wr_after_reset_quiet");
        do_read(0, AW'(3), 0, -1);

        // Requests during WAIT are dropped; back-to-back request accepted at once.
        do_write(0, AW'(1), {$urandom, $urandom, $urandom, $urandom}, 0);
        do_write(0, AW'(2), {$urandom, $urandom, $urandom, $urandom}, 0);
        do_read(0, AW'(1), 2, -1);
        idle(lat + beats + 2, "no_queue_quiet");
        do_read(0, AW'(2), 0, -1);
        do_read(0, AW'(1), 0, -1);

        // Reset during beat 3 of a read, then a normal read.
        do_read(0, AW'(7), 0, 3);
        do_read(0, AW'(7), 0, -1);

        rand_ops(0, 40);

        // Wide-bus, single-cycle-latency instance.
        select(1'b1);
        idle(2, "sel32_quiet");
        do_write(1, AW'(9), 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 0);
        do_read(1, AW'(9), 0, -1);
        do_read(1, AW'(9), 0, 2);
        do_read(1, AW'(9), 0, -1);
        rand_ops(1, 30);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
